// File: rtl/mmio_arbiter.sv
// Two-requester round-robin arbiter onto the shared MMIO peripheral bus.
// Registered grant, hold back-pressure, hold-timeout watchdog, per-requester read capture.
module mmio_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        R0_EN,
    input  logic        R0_WE,
    input  logic [29:0] R0_WADDR,
    input  logic [3:0]  R0_BE,
    input  logic [31:0] R0_DIN,
    output logic [31:0] R0_DOUT,
    output logic        R0_HOLD,
    input  logic        R1_EN,
    input  logic        R1_WE,
    input  logic [29:0] R1_WADDR,
    input  logic [3:0]  R1_BE,
    input  logic [31:0] R1_DIN,
    output logic [31:0] R1_DOUT,
    output logic        R1_HOLD,
    output logic        M_EN,
    output logic        M_WE,
    output logic [29:0] M_WADDR,
    output logic [3:0]  M_BE,
    output logic [31:0] M_DIN,
    input  logic [31:0] M_DOUT,
    input  logic        M_HOLD,
    output logic        ERR
);

    localparam int unsigned TO_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned HCNT_W  = (TO_BITS > 8) ? TO_BITS : 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic                err_q, err_d;
    logic                rdv_q, rdv_d;
    logic                own_q, own_d;
    logic                abt_q, abt_d;
    logic [31:0]         dq0_q, dq0_d;
    logic [31:0]         dq1_q, dq1_d;

    logic                sel;
    logic                done;
    logic                tmo;
    logic                cur_we;
    logic                oth_en;
    logic [31:0]         ret_data;

    // Next-state, bus command drive, completion and watchdog
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        hcnt_d     = hcnt_q;
        err_d      = err_q;
        rdv_d      = 1'b0;
        own_d      = own_q;
        abt_d      = abt_q;
        sel        = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        cur_we     = 1'b0;
        oth_en     = 1'b0;
        M_EN       = 1'b0;
        M_WE       = 1'b0;
        M_WADDR    = '0;
        M_BE       = '0;
        M_DIN      = '0;

        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                if (R0_EN && R1_EN) begin
                    state_d = last_gnt_q ? BUSY0 : BUSY1;
                end else if (R0_EN) begin
                    state_d = BUSY0;
                end else if (R1_EN) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                sel     = (state_q == BUSY1);
                cur_we  = sel ? R1_WE : R0_WE;
                oth_en  = sel ? R0_EN : R1_EN;
                M_EN    = 1'b1;
                M_WE    = cur_we;
                M_WADDR = sel ? R1_WADDR : R0_WADDR;
                M_BE    = sel ? R1_BE    : R0_BE;
                M_DIN   = sel ? R1_DIN   : R0_DIN;
                tmo     = (TIMEOUT != 0) && M_HOLD && (hcnt_q == HCNT_W'(TIMEOUT));
                done    = !M_HOLD || tmo;
                if (done) begin
                    last_gnt_d = sel;
                    hcnt_d     = '0;
                    err_d      = err_q | tmo;
                    if (!cur_we) begin
                        rdv_d = 1'b1;
                        own_d = sel;
                        abt_d = tmo;
                    end
                    // The completing requester's EN is spent; only the other side can follow
                    if (oth_en) begin
                        state_d = sel ? BUSY0 : BUSY1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hcnt_q != '1) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign R0_HOLD = R0_EN & ~(done & ~sel);
    assign R1_HOLD = R1_EN & ~(done &  sel);

    // Read return: live data to the owner for one cycle, captured value otherwise
    assign ret_data = abt_q ? ERR_DATA : M_DOUT;
    assign dq0_d    = (rdv_q && !own_q) ? ret_data : dq0_q;
    assign dq1_d    = (rdv_q &&  own_q) ? ret_data : dq1_q;
    assign R0_DOUT  = dq0_d;
    assign R1_DOUT  = dq1_d;
    assign ERR      = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            hcnt_q     <= '0;
            err_q      <= 1'b0;
            rdv_q      <= 1'b0;
            own_q      <= 1'b0;
            abt_q      <= 1'b0;
            dq0_q      <= '0;
            dq1_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            hcnt_q     <= hcnt_d;
            err_q      <= err_d;
            rdv_q      <= rdv_d;
            own_q      <= own_d;
            abt_q      <= abt_d;
            dq0_q      <= dq0_d;
            dq1_q      <= dq1_d;
        end
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed scenarios, then random traffic against a
// transaction-level memory model and a fairness/latency model.
module tb_mmio_arbiter;

    localparam int unsigned TO     = 4;
    localparam logic [29:0] A_READ = 30'h04400000;
    localparam logic [29:0] A_LEDS = 30'h04420000;
    localparam logic [29:0] A_SSEG = 30'h04430000;

    logic        CLK;
    logic        RST;
    logic        R0_EN, R0_WE, R0_HOLD;
    logic [29:0] R0_WADDR;
    logic [3:0]  R0_BE;
    logic [31:0] R0_DIN, R0_DOUT;
    logic        R1_EN, R1_WE, R1_HOLD;
    logic [29:0] R1_WADDR;
    logic [3:0]  R1_BE;
    logic [31:0] R1_DIN, R1_DOUT;
    logic        M_EN, M_WE, M_HOLD, ERR;
    logic [29:0] M_WADDR;
    logic [3:0]  M_BE;
    logic [31:0] M_DIN, M_DOUT;

    int total = 0;
    int bad   = 0;

    mmio_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
        .CLK(CLK), .RST(RST),
        .R0_EN(R0_EN), .R0_WE(R0_WE), .R0_WADDR(R0_WADDR), .R0_BE(R0_BE),
        .R0_DIN(R0_DIN), .R0_DOUT(R0_DOUT), .R0_HOLD(R0_HOLD),
        .R1_EN(R1_EN), .R1_WE(R1_WE), .R1_WADDR(R1_WADDR), .R1_BE(R1_BE),
        .R1_DIN(R1_DIN), .R1_DOUT(R1_DOUT), .R1_HOLD(R1_HOLD),
        .M_EN(M_EN), .M_WE(M_WE), .M_WADDR(M_WADDR), .M_BE(M_BE),
        .M_DIN(M_DIN), .M_DOUT(M_DOUT), .M_HOLD(M_HOLD), .ERR(ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        R0_EN = 0; R0_WE = 0; R0_WADDR = '0; R0_BE = '0; R0_DIN = '0;
        R1_EN = 0; R1_WE = 0; R1_WADDR = '0; R1_BE = '0; R1_DIN = '0;
        M_HOLD = 0; M_DOUT = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    // Random-phase state: requester intents, shadow memory, peripheral memory
    logic [31:0] smem [16];
    logic [31:0] pmem [16];
    logic [31:0] exp_dout [2];
    logic [31:0] nxt_dout [2];
    logic        nxt_v [2];
    logic        act [2];
    logic        rwe [2];
    logic [29:0] radr [2];
    logic [3:0]  rbe [2];
    logic [31:0] rdin [2];
    int          waitc [2];
    int          odone [2];
    logic        dn [2];
    logic        hld [2];
    logic [31:0] rd_pend;
    logic        rd_pend_v;
    int          hrun;
    int          left0, left1, own;

    initial begin
        RST = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        settle();
        chk("rst_men", 32'(M_EN), 0);
        chk("rst_maddr", 32'(M_WADDR), 0);
        chk("rst_dout0", R0_DOUT, 0);
        chk("rst_dout1", R1_DOUT, 0);
        chk("rst_err", 32'(ERR), 0);
        chk("rst_hold0", 32'(R0_HOLD), 0);

        // Single read
        R0_EN = 1; R0_WE = 0; R0_WADDR = A_READ;
        settle();
        chk("rd_arb_hold", 32'(R0_HOLD), 1);
        chk("rd_arb_men", 32'(M_EN), 0);
        step(); settle();
        chk("rd_men", 32'(M_EN), 1);
        chk("rd_addr", 32'(M_WADDR), 32'(A_READ));
        chk("rd_we", 32'(M_WE), 0);
        chk("rd_hold", 32'(R0_HOLD), 0);
        step();
        R0_EN = 0; M_DOUT = 32'h0000A5A5;
        settle();
        chk("rd_men_off", 32'(M_EN), 0);
        chk("rd_dout", R0_DOUT, 32'h0000A5A5);
        step();
        M_DOUT = 32'h5A5A0000;
        settle();
        chk("rd_dout_keep", R0_DOUT, 32'h0000A5A5);
        chk("rd_dout1_zero", R1_DOUT, 0);

        // Simultaneous writes, four each, alternating from R0
        do_reset();
        R0_EN = 1; R0_WE = 1; R0_WADDR = A_LEDS; R0_BE = 4'hF; R0_DIN = 32'h1234;
        R1_EN = 1; R1_WE = 1; R1_WADDR = A_SSEG; R1_BE = 4'hF; R1_DIN = 32'h5678;
        settle();
        chk("rr_arb_men", 32'(M_EN), 0);
        chk("rr_arb_h0", 32'(R0_HOLD), 1);
        chk("rr_arb_h1", 32'(R1_HOLD), 1);
        step();
        left0 = 4; left1 = 4;
        for (int k = 0; k < 8; k++) begin
            R0_EN = (left0 > 0);
            R1_EN = (left1 > 0);
            settle();
            own = k % 2;
            chk("rr_men", 32'(M_EN), 1);
            chk("rr_we", 32'(M_WE), 1);
            chk("rr_addr", 32'(M_WADDR), (own == 1) ? 32'(A_SSEG) : 32'(A_LEDS));
            chk("rr_din", M_DIN, (own == 1) ? 32'h5678 : 32'h1234);
            chk("rr_hold_own", 32'((own == 1) ? R1_HOLD : R0_HOLD), 0);
            chk("rr_hold_other", 32'((own == 1) ? R0_HOLD : R1_HOLD),
                32'((own == 1) ? R0_EN : R1_EN));
            if (own == 1) left1--; else left0--;
            step();
        end
        R0_EN = 0; R1_EN = 0;
        settle();
        chk("rr_end_men", 32'(M_EN), 0);

        // Peripheral stall of 3 cycles on an R1 read
        R1_EN = 1; R1_WE = 0; R1_WADDR = 30'h55; R1_BE = '0;
        settle();
        chk("st_arb_hold", 32'(R1_HOLD), 1);
        step();
        for (int k = 0; k < 4; k++) begin
            M_HOLD = (k < 3);
            settle();
            chk("st_men", 32'(M_EN), 1);
            chk("st_addr", 32'(M_WADDR), 32'h55);
            chk("st_we", 32'(M_WE), 0);
            chk("st_hold", 32'(R1_HOLD), 32'(k < 3));
            chk("st_err", 32'(ERR), 0);
            step();
        end
        R1_EN = 0; M_HOLD = 0; M_DOUT = 32'hC3C30001;
        settle();
        chk("st_dout", R1_DOUT, 32'hC3C30001);
        chk("st_err_after", 32'(ERR), 0);
        chk("st_men_off", 32'(M_EN), 0);
        step();

        // Watchdog abort: hold stuck on an R0 read
        R0_EN = 1; R0_WE = 0; R0_WADDR = 30'h77; M_HOLD = 1;
        settle();
        step();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("to_men", 32'(M_EN), 1);
            chk("to_hold", 32'(R0_HOLD), 1);
            chk("to_err_pre", 32'(ERR), 0);
            step();
        end
        settle();
        chk("to_done_hold", 32'(R0_HOLD), 0);
        chk("to_men_last", 32'(M_EN), 1);
        step();
        R0_EN = 0; M_HOLD = 0; M_DOUT = 32'h12345678;
        settle();
        chk("to_dout", R0_DOUT, 32'hDEADBEEF);
        chk("to_err", 32'(ERR), 1);
        chk("to_men_off", 32'(M_EN), 0);
        step();
        R1_EN = 1; R1_WE = 0; R1_WADDR = 30'h66;
        settle();
        step(); settle();
        chk("to_r1_men", 32'(M_EN), 1);
        chk("to_r1_hold", 32'(R1_HOLD), 0);
        step();
        R1_EN = 0; M_DOUT = 32'hBEEF0002;
        settle();
        chk("to_r1_dout", R1_DOUT, 32'hBEEF0002);
        chk("to_err_sticky", 32'(ERR), 1);
        chk("to_r0_keep", R0_DOUT, 32'hDEADBEEF);
        step();

        // Reset in the middle of a stalled access
        R0_EN = 1; R0_WE = 0; R0_WADDR = 30'h99; M_HOLD = 1;
        settle();
        step(); settle();
        chk("rs_men_pre", 32'(M_EN), 1);
        RST = 1;
        step(); settle();
        chk("rs_men", 32'(M_EN), 0);
        chk("rs_err", 32'(ERR), 0);
        chk("rs_dout0", R0_DOUT, 0);
        chk("rs_dout1", R1_DOUT, 0);
        chk("rs_hold", 32'(R0_HOLD), 1);
        RST = 0; M_HOLD = 0;
        step(); settle();
        chk("rs_regrant", 32'(M_EN), 1);
        chk("rs_addr", 32'(M_WADDR), 32'h99);
        chk("rs_hold_done", 32'(R0_HOLD), 0);
        step();
        R0_EN = 0; M_DOUT = 32'h4444;
        settle();
        chk("rs_dout_new", R0_DOUT, 32'h4444);
        step();

        // DOUT isolation between requesters
        R0_EN = 1; R0_WE = 0; R0_WADDR = 30'h10;
        settle();
        step(); settle();
        chk("iso_r0_men", 32'(M_EN), 1);
        step();
        R0_EN = 0; R1_EN = 1; R1_WE = 0; R1_WADDR = 30'h20; M_DOUT = 32'h1111;
        settle();
        chk("iso_r0", R0_DOUT, 32'h1111);
        chk("iso_r1_before", R1_DOUT, 0);
        step();
        M_DOUT = 32'hFFFF;
        settle();
        chk("iso_r0_busy", R0_DOUT, 32'h1111);
        chk("iso_r1_addr", 32'(M_WADDR), 32'h20);
        step();
        R1_EN = 0; M_DOUT = 32'h2222;
        settle();
        chk("iso_r1", R1_DOUT, 32'h2222);
        chk("iso_r0_keep", R0_DOUT, 32'h1111);
        step();
        M_DOUT = 32'h0;
        settle();
        chk("iso_r0_final", R0_DOUT, 32'h1111);
        chk("iso_r1_final", R1_DOUT, 32'h2222);

        // Random traffic against the transaction-level model
        do_reset();
        for (int a = 0; a < 16; a++) begin
            smem[a] = $urandom;
            pmem[a] = smem[a];
        end
        for (int i = 0; i < 2; i++) begin
            exp_dout[i] = '0; nxt_dout[i] = '0; nxt_v[i] = 0; act[i] = 0;
            rwe[i] = 0; radr[i] = '0; rbe[i] = '0; rdin[i] = '0;
            waitc[i] = 0; odone[i] = 0;
        end
        rd_pend = '0; rd_pend_v = 0; hrun = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!act[i] && cyc < 560 && $urandom_range(0, 2) != 0) begin
                    act[i]   = 1;
                    rwe[i]   = 1'($urandom_range(0, 1));
                    radr[i]  = 30'($urandom_range(0, 15));
                    rbe[i]   = 4'($urandom_range(1, 15));
                    rdin[i]  = $urandom;
                    waitc[i] = 0;
                    odone[i] = 0;
                end
            end
            R0_EN = act[0]; R0_WE = rwe[0]; R0_WADDR = radr[0]; R0_BE = rbe[0]; R0_DIN = rdin[0];
            R1_EN = act[1]; R1_WE = rwe[1]; R1_WADDR = radr[1]; R1_BE = rbe[1]; R1_DIN = rdin[1];
            M_DOUT = rd_pend_v ? rd_pend : $urandom;
            rd_pend_v = 0;
            M_HOLD = (hrun >= 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
            hrun = M_HOLD ? hrun + 1 : 0;
            settle();
            chk("rnd_dout0", R0_DOUT, exp_dout[0]);
            chk("rnd_dout1", R1_DOUT, exp_dout[1]);
            hld[0] = R0_HOLD; hld[1] = R1_HOLD;
            for (int i = 0; i < 2; i++) dn[i] = act[i] && !hld[i];
            chk("rnd_one_done", 32'(dn[0] && dn[1]), 0);
            for (int i = 0; i < 2; i++) begin
                if (act[i]) waitc[i]++;
                if (dn[i]) begin
                    chk("rnd_latency", 32'(waitc[i] > 8), 0);
                    chk("rnd_fair", 32'(odone[i] > 1), 0);
                    if (rwe[i]) begin
                        smem[radr[i][3:0]] = merge(smem[radr[i][3:0]], rdin[i], rbe[i]);
                    end else begin
                        nxt_v[i]    = 1;
                        nxt_dout[i] = smem[radr[i][3:0]];
                    end
                    if (act[1-i]) odone[1-i]++;
                    act[i] = 0;
                end
            end
            if (M_EN && !M_HOLD) begin
                if (M_WE) begin
                    pmem[M_WADDR[3:0]] = merge(pmem[M_WADDR[3:0]], M_DIN, M_BE);
                end else begin
                    rd_pend   = pmem[M_WADDR[3:0]];
                    rd_pend_v = 1;
                end
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (nxt_v[i]) begin
                    exp_dout[i] = nxt_dout[i];
                    nxt_v[i]    = 0;
                end
            end
        end
        R0_EN = 0; R1_EN = 0; M_HOLD = 0;
        settle();
        chk("rnd_drained", 32'({act[0], act[1]}), 0);
        chk("rnd_men_idle", 32'(M_EN), 0);
        chk("rnd_err", 32'(ERR), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
